// File: rtl/temp_sensor_reader.sv
// Polls a 10-bit serial temperature sensor (ready, data[7:0], even parity) and presents the last good reading on Temp.
// Temp/Temp_Valid update 1 CLK after the low half-period that follows the parity sample; define TEMP_AVG_EN for a 4-sample mean.
module temp_sensor_reader #(
  parameter int         CLK_DIV     = 2,
  parameter int         POLL_CYCLES = 200,
  parameter logic [7:0] TEMP_INIT   = 8'd70
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Sensor_SDO,
  output logic       Sensor_CS_n,
  output logic       Sensor_SCLK,
  output logic [7:0] Temp,
  output logic       Temp_Valid,
  output logic       Sensor_Err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_RELOAD  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, CHECK} state_t;

  state_t          state_q;
  logic [PW-1:0]   poll_q;
  logic [DW-1:0]   div_q;
  logic [3:0]      bit_q;
  logic [9:0]      shift_q;
  logic            cs_n_q;
  logic            sclk_q;
  logic [7:0]      temp_q;
  logic            valid_q;
  logic            err_q;

  logic            div_done;
  logic            poll_expired;
  logic            frame_end;
  logic            ready_bit;
  logic            par_ok;
  logic            accept;
  logic [7:0]      data_w;
  logic [9:0]      shift_d;
  logic [7:0]      temp_d;

  assign div_done     = (div_q == '0);
  assign poll_expired = Enable && (poll_q == '0);
  assign frame_end    = (state_q == SHIFT) && div_done && !sclk_q && (bit_q == 4'd10);
  assign ready_bit    = shift_q[9];
  assign data_w       = shift_q[8:1];
  assign par_ok       = ~^shift_q[8:0];
  assign accept       = frame_end && !ready_bit && par_ok;
  assign shift_d      = {shift_q[8:0], Sensor_SDO};

`ifdef TEMP_AVG_EN
  logic [3:0][7:0] hist_q;
  logic            primed_q;
  logic [3:0][7:0] hist_d;
  logic [9:0]      sum_d;

  // The first accepted sample seeds every history slot so the mean starts at that value.
  always_comb begin
    hist_d[0] = data_w;
    hist_d[1] = primed_q ? hist_q[0] : data_w;
    hist_d[2] = primed_q ? hist_q[1] : data_w;
    hist_d[3] = primed_q ? hist_q[2] : data_w;
    sum_d     = {2'b00, hist_d[0]} + {2'b00, hist_d[1]} + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
    temp_d    = sum_d[9:2];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      hist_q   <= '0;
      primed_q <= 1'b0;
    end else if (accept) begin
      hist_q   <= hist_d;
      primed_q <= 1'b1;
    end
  end
`else
  assign temp_d = data_w;
`endif

  // Free-running while enabled, even mid-frame; an expiry outside IDLE is simply dropped.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      poll_q <= '0;
    end else if (!Enable) begin
      poll_q <= '0;
    end else if (poll_q == '0) begin
      poll_q <= POLL_RELOAD;
    end else begin
      poll_q <= poll_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      temp_q  <= TEMP_INIT;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (poll_expired) begin
            state_q <= SELECT;
            cs_n_q  <= 1'b0;
            div_q   <= DIV_RELOAD;
          end
        end
        SELECT: begin
          if (div_done) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            shift_q <= shift_d;
            bit_q   <= 4'd1;
            div_q   <= DIV_RELOAD;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        SHIFT: begin
          if (!div_done) begin
            div_q <= div_q - 1'b1;
          end else if (sclk_q) begin
            sclk_q <= 1'b0;
            div_q  <= DIV_RELOAD;
          end else if (bit_q == 4'd10) begin
            state_q <= CHECK;
            cs_n_q  <= 1'b1;
            if (!ready_bit) begin
              if (par_ok) begin
                temp_q  <= temp_d;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end else begin
            sclk_q  <= 1'b1;
            shift_q <= shift_d;
            bit_q   <= bit_q + 1'b1;
            div_q   <= DIV_RELOAD;
          end
        end
        CHECK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Sensor_CS_n = cs_n_q;
  assign Sensor_SCLK = sclk_q;
  assign Temp        = temp_q;
  assign Temp_Valid  = valid_q;
  assign Sensor_Err  = err_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: directed frames into a serial sensor model, scoreboarded at each frame end.
module tb_temp_sensor_reader;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Sensor_SDO;
  logic       Sensor_CS_n;
  logic       Sensor_SCLK;
  logic [7:0] Temp;
  logic       Temp_Valid;
  logic       Sensor_Err;

  always #5 CLK = ~CLK;

  temp_sensor_reader #(
    .CLK_DIV    (1),
    .POLL_CYCLES(64),
    .TEMP_INIT  (8'd70)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Enable     (Enable),
    .Sensor_SDO (Sensor_SDO),
    .Sensor_CS_n(Sensor_CS_n),
    .Sensor_SCLK(Sensor_SCLK),
    .Temp       (Temp),
    .Temp_Valid (Temp_Valid),
    .Sensor_Err (Sensor_Err)
  );

  typedef struct packed {
    logic       ready;
    logic [7:0] data;
    logic       par;
    logic       ev;
    logic [7:0] et;
    logic       ee;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [7:0] t;
    logic       e;
    logic       gap;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  int nchecks = 0;
  int nerrors = 0;
  int fall_cnt = 0;
  int valid_cnt = 0;
  int exp_valids = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sensor model: first bit appears at CS_n fall, later bits after each SCLK fall.
  logic [9:0] next_frame;
  logic [9:0] cur_frame;
  int         sidx = 0;

  always @(negedge Sensor_CS_n) begin
    cur_frame = next_frame;
    sidx = 0;
    #1 Sensor_SDO = cur_frame[9];
  end

  always @(negedge Sensor_SCLK) begin
    sidx = sidx + 1;
    if (sidx > 0 && sidx < 10) #1 Sensor_SDO = cur_frame[9 - sidx];
  end

  // Monitor: frame end (CS_n rise) pops the scoreboard.
  int   cyc = 0;
  int   last_fall = 0;
  int   gap_cur = 0;
  bit   have_fall = 0;
  logic prev_cs = 1'b1;
  int   mon_idx = 0;

  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      prev_cs   = 1'b1;
      have_fall = 0;
    end else begin
      if (Temp_Valid === 1'b1) valid_cnt++;
      if (prev_cs === 1'b1 && Sensor_CS_n === 1'b0) begin
        fall_cnt++;
        if (have_fall) gap_cur = cyc - last_fall;
        last_fall = cyc;
        have_fall = 1;
      end
      if (prev_cs === 1'b0 && Sensor_CS_n === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_end", 1, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("frame%0d_valid", mon_idx), int'(Temp_Valid), int'(e.v));
          chk($sformatf("frame%0d_temp", mon_idx), int'(Temp), int'(e.t));
          chk($sformatf("frame%0d_err", mon_idx), int'(Sensor_Err), int'(e.e));
          if (e.gap) chk($sformatf("frame%0d_start_gap", mon_idx), gap_cur, 64);
          mon_idx++;
        end
      end
      prev_cs = Sensor_CS_n;
    end
  end

  task automatic wait_cs(input logic lvl, input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (Sensor_CS_n === lvl) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    int   falls0;
    exp_t e;

`ifdef TEMP_AVG_EN
    vecs[0] = {1'b0, 8'h50, 1'b0, 1'b1, 8'd80, 1'b0};
    vecs[1] = {1'b0, 8'h3C, 1'b0, 1'b1, 8'd75, 1'b0};
    vecs[2] = {1'b0, 8'h3C, 1'b0, 1'b1, 8'd70, 1'b0};
    vecs[3] = {1'b0, 8'h3C, 1'b0, 1'b1, 8'd65, 1'b0};
    vecs[4] = {1'b0, 8'h46, 1'b0, 1'b0, 8'd65, 1'b1};
    vecs[5] = {1'b1, 8'h5D, 1'b1, 1'b0, 8'd65, 1'b1};
    vecs[6] = {1'b0, 8'h46, 1'b1, 1'b1, 8'd62, 1'b0};
    vecs[7] = {1'b0, 8'h21, 1'b0, 1'b1, 8'd55, 1'b0};
`else
    vecs[0] = {1'b0, 8'h5D, 1'b1, 1'b1, 8'd93,  1'b0};
    vecs[1] = {1'b0, 8'h3C, 1'b0, 1'b1, 8'd60,  1'b0};
    vecs[2] = {1'b0, 8'h46, 1'b0, 1'b0, 8'd60,  1'b1};
    vecs[3] = {1'b1, 8'h46, 1'b1, 1'b0, 8'd60,  1'b1};
    vecs[4] = {1'b0, 8'h46, 1'b1, 1'b1, 8'd70,  1'b0};
    vecs[5] = {1'b1, 8'h5D, 1'b1, 1'b0, 8'd70,  1'b0};
    vecs[6] = {1'b0, 8'hFF, 1'b0, 1'b1, 8'd255, 1'b0};
    vecs[7] = {1'b0, 8'h21, 1'b0, 1'b1, 8'd33,  1'b0};
`endif

    Reset = 1'b1;
    Enable = 1'b0;
    Sensor_SDO = 1'b0;
    next_frame = '0;
    repeat (3) @(negedge CLK);
    chk("rst_cs_n", int'(Sensor_CS_n), 1);
    chk("rst_sclk", int'(Sensor_SCLK), 0);
    chk("rst_temp", int'(Temp), 70);
    chk("rst_valid", int'(Temp_Valid), 0);
    chk("rst_err", int'(Sensor_Err), 0);

    // Abort a frame mid-shift with an asynchronous reset while SCLK is high.
    Reset = 1'b0;
    Enable = 1'b1;
    next_frame = {1'b0, 8'h3C, 1'b0};
    wait_cs(1'b0, 10, ok);
    chk("abort_frame_start", int'(ok), 1);
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (Sensor_SCLK === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk("abort_sclk_high_seen", int'(ok), 1);
    #2 Reset = 1'b1;
    #1;
    chk("abort_cs_n_async", int'(Sensor_CS_n), 1);
    chk("abort_sclk_async", int'(Sensor_SCLK), 0);
    chk("abort_temp", int'(Temp), 70);
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      next_frame = {vecs[i].ready, vecs[i].data, vecs[i].par};
      e.v = vecs[i].ev;
      e.t = vecs[i].et;
      e.e = vecs[i].ee;
      e.gap = (i != 0);
      sb.push_back(e);
      if (vecs[i].ev) exp_valids++;
      if (i == 0) Reset = 1'b0;
      wait_cs(1'b0, 200, ok);
      chk($sformatf("frame%0d_start_timeout", i), int'(ok), 1);
      if (i == 7) begin
        repeat (5) @(negedge CLK);
        Enable = 1'b0;
      end
      wait_cs(1'b1, 100, ok);
      chk($sformatf("frame%0d_end_timeout", i), int'(ok), 1);
    end

    falls0 = fall_cnt;
    repeat (150) @(negedge CLK);
    chk("no_frame_after_disable", fall_cnt, falls0);
    chk("idle_cs_n", int'(Sensor_CS_n), 1);
    chk("idle_sclk", int'(Sensor_SCLK), 0);
    chk("valid_pulse_count", valid_cnt, exp_valids);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
